// File: rtl/lisp_defs.sv
// rtl/lisp_defs.sv - shared types and constants for the cell-memory datapath
package lisp_defs;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

   // Error code the evaluator core loads when a memory access times out.
   localparam logic [15:0] MEM_TIMEOUT_ERROR = 16'h00E1;

   // Wait counter is sized for the largest allowed TIMEOUT (255).
   localparam int ARB_CNT_W = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin winner selection over a request vector
// Scans upward from rr_ptr with wrap; rr_ptr moves past the served index on update.
module rr_picker
   import lisp_defs::*;
#(
   parameter int NUM_REQ = 3,
   localparam int IDX_W  = idx_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               update,
   input  logic [IDX_W-1:0]   update_idx,
   output logic               any_valid,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] cand;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (update) begin
         rr_ptr_d = (update_idx == IDX_W'(NUM_REQ - 1)) ? '0 : update_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      any_valid = 1'b0;
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!any_valid && valid[cand]) begin
            any_valid = 1'b1;
            grant_idx = cand;
         end
      end
      if (any_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter owning the single cell-memory port
// One transaction in flight at a time: accept, issue, wait (with timeout), respond.
module mem_arbiter
   import lisp_defs::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic                      timeout_flag,
   output logic                      busy,
   output logic                      mem_req,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_write_enable,
   output logic [DATA_W-1:0]         mem_write_data,
   input  logic                      mem_data_ready,
   input  logic [DATA_W-1:0]         mem_data_out,
   input  logic [ADDR_W-1:0]         mem_write_result_addr
);

   localparam int IDX_W = idx_width(NUM_REQ);

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
   logic                   wr_q, wr_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
   logic [ARB_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   timeout_flag_q, timeout_flag_d;

   logic                   pick_any;
   logic [NUM_REQ-1:0]     pick_grant;
   logic [IDX_W-1:0]       pick_idx;
   logic                   rr_update;
   logic                   sel_write;
   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_wdata;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_picker (
      .clk        (clk),
      .rst        (rst),
      .valid      (req_valid),
      .update     (rr_update),
      .update_idx (gnt_idx_q),
      .any_valid  (pick_any),
      .grant      (pick_grant),
      .grant_idx  (pick_idx)
   );

   // Payload of the current round-robin winner.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      gnt_idx_d        = gnt_idx_q;
      wr_d             = wr_q;
      mem_addr_d       = mem_addr_q;
      mem_wdata_d      = mem_wdata_q;
      wait_cnt_d       = wait_cnt_q;
      rsp_data_d       = rsp_data_q;
      rsp_err_d        = rsp_err_q;
      timeout_flag_d   = timeout_flag_q;
      req_ready        = '0;
      rsp_valid        = '0;
      mem_req          = 1'b0;
      mem_write_enable = 1'b0;
      rr_update        = 1'b0;
      busy             = (state_q != ARB_IDLE);

      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               req_ready   = pick_grant;
               gnt_idx_d   = pick_idx;
               wr_d        = sel_write;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
               state_d     = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            mem_req          = !wr_q;
            mem_write_enable = wr_q;
            wait_cnt_d       = '0;
            state_d          = ARB_WAIT;
         end
         ARB_WAIT: begin
            // A completion in the final wait cycle still counts as success.
            if (mem_data_ready) begin
               rsp_data_d = wr_q ? DATA_W'(mem_write_result_addr) : mem_data_out;
               rsp_err_d  = 1'b0;
               state_d    = ARB_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + ARB_CNT_W'(1);
               if (wait_cnt_d == ARB_CNT_W'(TIMEOUT)) begin
                  rsp_data_d     = '0;
                  rsp_err_d      = 1'b1;
                  timeout_flag_d = 1'b1;
                  state_d        = ARB_RESP;
               end
            end
         end
         ARB_RESP: begin
            rsp_valid[gnt_idx_q] = 1'b1;
            rr_update            = 1'b1;
            state_d              = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      if (rst) begin
         req_ready = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ARB_IDLE;
         gnt_idx_q      <= '0;
         wr_q           <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         wait_cnt_q     <= '0;
         rsp_data_q     <= '0;
         rsp_err_q      <= 1'b0;
         timeout_flag_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_idx_q      <= gnt_idx_d;
         wr_q           <= wr_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         wait_cnt_q     <= wait_cnt_d;
         rsp_data_q     <= rsp_data_d;
         rsp_err_q      <= rsp_err_d;
         timeout_flag_q <= timeout_flag_d;
      end
   end

   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_wdata_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_err        = rsp_err_q;
   assign timeout_flag   = timeout_flag_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_write;
   logic [35:0] req_addr;
   logic [47:0] req_wdata;
   logic [2:0]  req_ready;
   logic [2:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        timeout_flag;
   logic        busy;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic        mem_write_enable;
   logic [15:0] mem_write_data;
   logic        mem_data_ready;
   logic [15:0] mem_data_out;
   logic [11:0] mem_write_result_addr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2:0] gq[$];
   int         cq[$];
   logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic       last_req;
   logic       seen;
   int         n;

   mem_arbiter dut (
      .clk                   (clk),
      .rst                   (rst),
      .req_valid             (req_valid),
      .req_write             (req_write),
      .req_addr              (req_addr),
      .req_wdata             (req_wdata),
      .req_ready             (req_ready),
      .rsp_valid             (rsp_valid),
      .rsp_data              (rsp_data),
      .rsp_err               (rsp_err),
      .timeout_flag          (timeout_flag),
      .busy                  (busy),
      .mem_req               (mem_req),
      .mem_addr              (mem_addr),
      .mem_write_enable      (mem_write_enable),
      .mem_write_data        (mem_write_data),
      .mem_data_ready        (mem_data_ready),
      .mem_data_out          (mem_data_out),
      .mem_write_result_addr (mem_write_result_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr = '0;
      req_wdata = '0;
      mem_data_ready = 1'b0;
      mem_data_out = '0;
      mem_write_result_addr = '0;
      tick;
      tick;
      rst = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_tflag", timeout_flag, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_write_enable, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_write_data, 0);

      // Single read: requester 0, memory answers two cycles after mem_req.
      req_addr[11:0] = 12'h005;
      req_valid = 3'b001;
      #1;
      check("rd_ready", req_ready, 3'b001);
      tick;
      req_valid = '0;
      #1;
      check("rd_mem_req", mem_req, 1);
      check("rd_mem_addr", mem_addr, 12'h005);
      check("rd_mem_we", mem_write_enable, 0);
      tick;
      check("rd_wait_busy", busy, 1);
      check("rd_wait_rsp", rsp_valid, 0);
      tick;
      mem_data_ready = 1'b1;
      mem_data_out = 16'h1234;
      tick;
      mem_data_ready = 1'b0;
      #1;
      check("rd_rsp_valid", rsp_valid, 3'b001);
      check("rd_rsp_data", rsp_data, 16'h1234);
      check("rd_rsp_err", rsp_err, 0);
      tick;
      check("rd_idle_busy", busy, 0);
      check("rd_hold_data", rsp_data, 16'h1234);

      // Write: requester 1 allocates, memory reports address 0x010.
      req_write = 3'b010;
      req_wdata[31:16] = 16'h2007;
      req_valid = 3'b010;
      #1;
      check("wr_ready", req_ready, 3'b010);
      tick;
      req_valid = '0;
      #1;
      check("wr_mem_we", mem_write_enable, 1);
      check("wr_mem_req", mem_req, 0);
      check("wr_mem_wdata", mem_write_data, 16'h2007);
      mem_data_ready = 1'b1;
      mem_write_result_addr = 12'h010;
      tick;
      check("wr_we_once", mem_write_enable, 0);
      check("wr_wdata_hold", mem_write_data, 16'h2007);
      tick;
      mem_data_ready = 1'b0;
      #1;
      check("wr_rsp_valid", rsp_valid, 3'b010);
      check("wr_rsp_data", rsp_data, 16'h0010);
      check("wr_rsp_err", rsp_err, 0);
      tick;
      req_write = '0;

      // Completion on the 15th wait cycle: data wins over timeout.
      req_addr[35:24] = 12'h0AB;
      req_valid = 3'b100;
      #1;
      check("sim_ready", req_ready, 3'b100);
      tick;
      req_valid = '0;
      #1;
      check("sim_mem_req", mem_req, 1);
      repeat (15) tick;
      #1;
      check("sim_no_early", rsp_valid, 0);
      check("sim_busy", busy, 1);
      check("sim_addr_hold", mem_addr, 12'h0AB);
      mem_data_ready = 1'b1;
      mem_data_out = 16'h5A5A;
      tick;
      mem_data_ready = 1'b0;
      #1;
      check("sim_rsp_valid", rsp_valid, 3'b100);
      check("sim_rsp_err", rsp_err, 0);
      check("sim_rsp_data", rsp_data, 16'h5A5A);
      check("sim_tflag", timeout_flag, 0);
      tick;

      // Round-robin with all three requesters held high from reset.
      rst = 1'b1;
      tick;
      rst = 1'b0;
      mem_data_out = 16'hBEEF;
      req_valid = 3'b111;
      last_req = 1'b0;
      for (int c = 0; c < 16; c++) begin
         #1;
         if (req_ready != 3'b000) begin
            gq.push_back(req_ready);
            cq.push_back(c);
         end
         if (c == 15) req_valid = '0;
         tick;
         mem_data_ready = last_req;
         last_req = mem_req;
      end
      mem_data_ready = 1'b0;
      check("rr_count", gq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_grant%0d", i), (i < gq.size()) ? gq[i] : 3'b000, rr_exp[i]);
         if (i > 0) check($sformatf("rr_gap%0d", i), (i < cq.size()) ? cq[i] - cq[i-1] : 0, 4);
      end
      tick;

      // Timeout: memory never answers requester 1.
      req_addr[23:12] = 12'h3C0;
      req_valid = 3'b010;
      #1;
      check("to_ready", req_ready, 3'b010);
      tick;
      req_valid = '0;
      n = 1;
      while (rsp_valid == 3'b000 && n < 40) begin
         tick;
         n++;
      end
      check("to_latency", n, 17);
      check("to_rsp_valid", rsp_valid, 3'b010);
      check("to_rsp_err", rsp_err, 1);
      check("to_rsp_data", rsp_data, 0);
      check("to_tflag", timeout_flag, 1);
      tick;
      mem_data_ready = 1'b1;
      mem_data_out = 16'h7777;
      seen = 1'b0;
      repeat (3) begin
         tick;
         if (rsp_valid != 3'b000) seen = 1'b1;
      end
      mem_data_ready = 1'b0;
      check("late_no_rsp", seen, 0);
      check("late_busy", busy, 0);
      check("late_tflag", timeout_flag, 1);
      check("late_rsp_data", rsp_data, 0);

      // Reset while a read from requester 2 is waiting.
      req_addr[35:24] = 12'h1F3;
      req_wdata[47:32] = 16'hCAFE;
      req_valid = 3'b100;
      #1;
      check("mr_ready", req_ready, 3'b100);
      tick;
      req_valid = '0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_mem_addr", mem_addr, 0);
      check("mr_mem_wdata", mem_write_data, 0);
      check("mr_mem_req", mem_req, 0);
      check("mr_rsp_valid", rsp_valid, 0);
      check("mr_rsp_err", rsp_err, 0);
      check("mr_tflag", timeout_flag, 0);
      seen = 1'b0;
      repeat (5) begin
         tick;
         if (rsp_valid != 3'b000) seen = 1'b1;
      end
      check("mr_no_rsp", seen, 0);
      req_valid = 3'b111;
      #1;
      check("mr_ptr_zero", req_ready, 3'b001);
      tick;
      req_valid = '0;
      mem_data_ready = 1'b1;
      mem_data_out = 16'h0F0F;
      tick;
      tick;
      mem_data_ready = 1'b0;
      #1;
      check("mr_next_valid", rsp_valid, 3'b001);
      check("mr_next_data", rsp_data, 16'h0F0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
